// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD converter (double dabble, one shift per clock) with display hold.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bcd_display_ctrl #(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] digits,
  output logic           ovf,
  output logic [N-1:0]   blank
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W+31:0] MAXV = (W + 32)'(10 ** N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [4*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovfn_q, ovfn_d;
  logic [4*N-1:0] digits_q, digits_d;
  logic           ovf_q, ovf_d;
  logic [4*N-1:0] acc_adj, acc_shift;
  logic           last_shift;

  // Add-3 correction on every nibble, then shift the next binary bit in.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < N; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[4*N-2:0], sr_q[W-1]};
  end

  assign last_shift = (state_q == SHIFT) && (cnt_q == CW'(1));

  // The result is registered as the FSM enters DONE, so the done pulse coincides with fresh digits.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovfn_d   = ovfn_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = in_data;
          acc_d   = '0;
          cnt_d   = CW'(W);
          ovfn_d  = ({32'd0, in_data} > MAXV);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (last_shift) begin
          state_d  = DONE;
          digits_d = ovfn_q ? {N{4'd9}} : acc_shift;
          ovf_d    = ovfn_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
    end
  end

  // Working registers are only meaningful in SHIFT and are reloaded on every transfer.
  always_ff @(posedge clk) begin
    sr_q   <= sr_d;
    acc_q  <= acc_d;
    cnt_q  <= cnt_d;
    ovfn_q <= ovfn_d;
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign digits   = digits_q;
  assign ovf      = ovf_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [N-1:0] BLANK_RST = {N{1'b1}} << 1;

  logic [N-1:0] blank_q, blank_d;
  logic         lead_zero;

  always_comb begin
    blank_d   = blank_q;
    lead_zero = 1'b1;
    if (last_shift) begin
      blank_d = '0;
      for (int i = N - 1; i > 0; i--) begin
        lead_zero  = lead_zero && (acc_shift[4*i +: 4] == 4'd0);
        blank_d[i] = lead_zero && !ovfn_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blank_q <= BLANK_RST;
    else     blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: W=8/N=3 and W=10/N=3 instances checked every cycle
// against a decimal-arithmetic model, plus hand-computed literal expectations.
module tb_bcd_display_ctrl;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [2:0] BLK_RST = 3'b110;
`else
  localparam logic [2:0] BLK_RST = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        v8 = 1'b0, v10 = 1'b0;
  logic [7:0]  d8 = '0;
  logic [9:0]  d10 = '0;
  logic        rdy8, busy8, done8, ovf8, rdy10, busy10, done10, ovf10;
  logic [11:0] dig8, dig10;
  logic [2:0]  blk8, blk10;

  int checks = 0;
  int fails  = 0;

  int          m_cnt[2];
  int          m_val[2];
  logic [11:0] m_dig[2];
  logic        m_ovf[2];
  logic [2:0]  m_blk[2];

  always #5 clk = ~clk;

  bcd_display_ctrl #(.W(8), .N(3)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_data(d8), .in_ready(rdy8),
    .busy(busy8), .done(done8), .digits(dig8), .ovf(ovf8), .blank(blk8)
  );

  bcd_display_ctrl #(.W(10), .N(3)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(v10), .in_data(d10), .in_ready(rdy10),
    .busy(busy10), .done(done10), .digits(dig10), .ovf(ovf10), .blank(blk10)
  );

  function automatic logic [11:0] exp_dig(input int v);
    if (v > 999) return 12'h999;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] exp_blk(input int v);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if (v > 999) return 3'b000;
    return {v < 100, v < 10, 1'b0};
`else
    return (v < 0) ? 3'b111 : 3'b000;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transfer makes the block busy for W+1 cycles; the last of them is the done cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] <= 0;
        m_val[d] <= 0;
        m_dig[d] <= '0;
        m_ovf[d] <= 1'b0;
        m_blk[d] <= BLK_RST;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_cnt[d] == 0) begin
          if ((d == 0) ? v8 : v10) begin
            m_cnt[d] <= ((d == 0) ? 8 : 10) + 1;
            m_val[d] <= (d == 0) ? int'(d8) : int'(d10);
          end
        end else begin
          m_cnt[d] <= m_cnt[d] - 1;
          if (m_cnt[d] == 2) begin
            m_dig[d] <= exp_dig(m_val[d]);
            m_ovf[d] <= (m_val[d] > 999);
            m_blk[d] <= exp_blk(m_val[d]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("rdy8",   32'(rdy8),   32'(m_cnt[0] == 0));
      chk("busy8",  32'(busy8),  32'(m_cnt[0] != 0));
      chk("done8",  32'(done8),  32'(m_cnt[0] == 1));
      chk("dig8",   32'(dig8),   32'(m_dig[0]));
      chk("ovf8",   32'(ovf8),   32'(m_ovf[0]));
      chk("blk8",   32'(blk8),   32'(m_blk[0]));
      chk("rdy10",  32'(rdy10),  32'(m_cnt[1] == 0));
      chk("busy10", 32'(busy10), 32'(m_cnt[1] != 0));
      chk("done10", 32'(done10), 32'(m_cnt[1] == 1));
      chk("dig10",  32'(dig10),  32'(m_dig[1]));
      chk("ovf10",  32'(ovf10),  32'(m_ovf[1]));
      chk("blk10",  32'(blk10),  32'(m_blk[1]));
    end
  end

  task automatic send(input int d, input int val);
    int t = 0;
    @(negedge clk);
    if (d == 0) begin d8 = 8'(val); v8 = 1'b1; end
    else        begin d10 = 10'(val); v10 = 1'b1; end
    while (((d == 0) ? !rdy8 : !rdy10) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", 32'(t < 100), 32'd1);
    @(negedge clk);
    if (d == 0) v8 = 1'b0;
    else        v10 = 1'b0;
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (((d == 0) ? !done8 : !done10) && lat < 100);
    chk("done_timeout", 32'(lat < 100), 32'd1);
  endtask

  task automatic convert8(input int val, input logic [11:0] exp, input string nm);
    int lat;
    send(0, val);
    wait_done(0, lat);
    chk({nm, "_lat"}, 32'(lat), 32'd8);
    chk(nm, 32'(dig8), 32'(exp));
  endtask

  initial begin
    int lat;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    chk("rst_dig",   32'(dig8),  32'h000);
    chk("rst_ovf",   32'(ovf8),  32'd0);
    chk("rst_done",  32'(done8), 32'd0);
    chk("rst_busy",  32'(busy8), 32'd0);
    chk("rst_ready", 32'(rdy8),  32'd1);
    chk("rst_blank", 32'(blk8),  32'(BLK_RST));

    convert8(123, 12'h123, "basic_123");
    chk("basic_ovf", 32'(ovf8), 32'd0);
    @(negedge clk);
    chk("basic_ready_back", 32'(rdy8), 32'd1);

    convert8(0,   12'h000, "ext_0");
    convert8(255, 12'h255, "ext_255");
    convert8(99,  12'h099, "ext_99");

    send(0, 7);
    d8 = 8'd45;
    v8 = 1'b1;
    chk("hs_busy", 32'(rdy8), 32'd0);
    wait_done(0, lat);
    chk("hs_first", 32'(dig8), 32'h007);
    wait_done(0, lat);
    v8 = 1'b0;
    chk("hs_second", 32'(dig8), 32'h045);
    chk("hs_period", 32'(lat), 32'd10);

    send(0, 200);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_dig",   32'(dig8),  32'h000);
    chk("mid_rst_ovf",   32'(ovf8),  32'd0);
    chk("mid_rst_done",  32'(done8), 32'd0);
    chk("mid_rst_busy",  32'(busy8), 32'd0);
    chk("mid_rst_ready", 32'(rdy8),  32'd1);
    chk("mid_rst_blank", 32'(blk8),  32'(BLK_RST));
    @(negedge clk);
    rst = 1'b0;
    convert8(200, 12'h200, "after_rst_200");

    send(1, 1000);
    wait_done(1, lat);
    chk("w10_lat", 32'(lat), 32'd10);
    chk("w10_1000_dig", 32'(dig10), 32'h999);
    chk("w10_1000_ovf", 32'(ovf10), 32'd1);
    chk("w10_1000_blk", 32'(blk10), 32'b000);
    send(1, 7);
    wait_done(1, lat);
    chk("w10_7_dig", 32'(dig10), 32'h007);
    chk("w10_7_ovf", 32'(ovf10), 32'd0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    chk("w10_7_blk", 32'(blk10), 32'b110);
`else
    chk("w10_7_blk", 32'(blk10), 32'b000);
`endif
    send(1, 100);
    wait_done(1, lat);
    chk("w10_100_dig", 32'(dig10), 32'h100);
    chk("w10_100_blk", 32'(blk10), 32'b000);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
